// File: rtl/imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : imem_boot_loader
// Brief    : Loads the instruction RAM from a byte stream (count header then
//            little-endian words) and holds the core off fetch while loading.
// Revision : 1.0
// ============================================================================
module imem_boot_loader #(
    parameter int unsigned W         = 32,
    parameter int unsigned DEPTH     = 2048,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [7:0]   rx_data,
    input  logic         rx_valid,
    output logic         rx_ready,
    output logic         is_write,
    output logic [W-1:0] im_addr,
    output logic [W-1:0] im_inst,
    output logic         core_hold,
    output logic         load_done,
    output logic         load_err
);

    localparam int unsigned  IDX_W       = $clog2(DEPTH + 1);
    localparam logic [W-1:0] c_base_addr = W'(BASE_ADDR);
    localparam logic [31:0]  c_depth     = 32'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_bcnt;
    logic [23:0]      r_shift;
    logic [31:0]      r_n;
    logic [IDX_W-1:0] r_idx;

    logic             w_accept;
    logic             w_last_byte;
    logic [31:0]      w_word;
    logic [IDX_W-1:0] w_idx_next;
    logic             w_last_word;
    logic             w_rx_ready;
    logic             w_hold;

    assign w_accept    = rx_valid && rx_ready;
    assign w_last_byte = w_accept && (r_bcnt == 2'd3);
    // Newest byte is the most significant: four shifts give a little-endian word.
    assign w_word      = {rx_data, r_shift};
    assign w_idx_next  = r_idx + 1'b1;
    assign w_last_word = (32'(w_idx_next) == r_n);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_LEN;
            S_LEN: begin
                if (w_last_byte) begin
                    if (w_word == 32'd0)         w_next = S_DONE;
                    else if (w_word > c_depth)   w_next = S_ERR;
                    else                         w_next = S_DATA;
                end
            end
            S_DATA:  if (w_last_byte) w_next = S_WRITE;
            S_WRITE: w_next = w_last_word ? S_DONE : S_DATA;
            S_DONE:  w_next = S_IDLE;
            S_ERR:   if (start) w_next = S_LEN;
            default: w_next = S_IDLE;
        endcase

        // Outputs are registered, so they are decoded from the state being entered.
        w_rx_ready = (w_next == S_LEN) || (w_next == S_DATA);
        w_hold     = (w_next == S_LEN) || (w_next == S_DATA) ||
                     (w_next == S_WRITE) || (w_next == S_ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_bcnt    <= 2'd0;
            r_shift   <= 24'd0;
            r_n       <= 32'd0;
            r_idx     <= '0;
            rx_ready  <= 1'b0;
            is_write  <= 1'b0;
            im_addr   <= '0;
            im_inst   <= '0;
            core_hold <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            r_state   <= w_next;
            rx_ready  <= w_rx_ready;
            core_hold <= w_hold;
            is_write  <= (w_next == S_WRITE);
            load_done <= (w_next == S_DONE);
            load_err  <= (w_next == S_ERR);

            if (w_accept) begin
                r_shift <= w_word[31:8];
                r_bcnt  <= r_bcnt + 2'd1;
            end
            if ((r_state == S_LEN) && w_last_byte) begin
                r_n   <= w_word;
                r_idx <= '0;
            end
            if ((r_state == S_DATA) && w_last_byte) begin
                im_addr <= c_base_addr + (W'(r_idx) << 2);
                im_inst <= W'(w_word);
            end
            if (r_state == S_WRITE) begin
                r_idx <= w_idx_next;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_boot_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_imem_boot_loader
// Brief    : Scoreboard bench for imem_boot_loader (default and small-depth
//            instances sharing the byte stream).
// Revision : 1.0
// ============================================================================
module tb_imem_boot_loader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start0, start1, rx_valid;
    logic [7:0]  rx_data;
    logic        rdy0, wr0, hold0, done0, err0;
    logic [31:0] addr0, inst0;
    logic        rdy1, wr1, hold1, done1, err1;
    logic [31:0] addr1, inst1;

    imem_boot_loader #(.W(32), .DEPTH(2048), .BASE_ADDR(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rdy0), .is_write(wr0), .im_addr(addr0), .im_inst(inst0),
        .core_hold(hold0), .load_done(done0), .load_err(err0)
    );

    imem_boot_loader #(.W(32), .DEPTH(4), .BASE_ADDR(32'h100)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rdy1), .is_write(wr1), .im_addr(addr1), .im_inst(inst1),
        .core_hold(hold1), .load_done(done1), .load_err(err1)
    );

    logic [63:0] exp0[$];
    logic [63:0] exp1[$];
    logic [63:0] e0, e1;
    int errors = 0;
    int checks = 0;
    int done_cnt0 = 0;
    int done_cnt1 = 0;
    int sel = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: pop the expected (addr,inst) pair on every write pulse.
    always @(negedge clk) begin
        if (wr0 === 1'b1) begin
            if (exp0.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut0 unexpected write: got addr %h inst %h expected none", addr0, inst0);
            end else begin
                e0 = exp0.pop_front();
                check("dut0 write", {addr0, inst0}, e0);
                check("dut0 hold during write", 64'(hold0), 64'd1);
            end
        end
        if (done0 === 1'b1) begin
            done_cnt0++;
            check("dut0 done cycle hold/ready", 64'({hold0, rdy0}), 64'd0);
        end
    end

    always @(negedge clk) begin
        if (wr1 === 1'b1) begin
            if (exp1.size() == 0) begin
                checks++; errors++;
                $display("FAIL dut1 unexpected write: got addr %h inst %h expected none", addr1, inst1);
            end else begin
                e1 = exp1.pop_front();
                check("dut1 write", {addr1, inst1}, e1);
                check("dut1 hold during write", 64'(hold1), 64'd1);
            end
        end
        if (done1 === 1'b1) begin
            done_cnt1++;
            check("dut1 done cycle hold/ready", 64'({hold1, rdy1}), 64'd0);
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        t = 0;
        while (!((sel == 1) ? rdy1 : rdy0) && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (t >= 400) begin
            checks++; errors++;
            $display("FAIL byte accept timeout: got rx_ready 0 expected 1 (byte %h)", b);
            rx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 rx_valid = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
    endtask

    task automatic pulse_start(input int s);
        @(negedge clk);
        if (s == 1) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int s, input int target, input string name);
        int t;
        t = 0;
        while (((s == 1) ? done_cnt1 : done_cnt0) < target && t < 500) begin
            @(negedge clk);
            t++;
        end
        check(name, 64'(((s == 1) ? done_cnt1 : done_cnt0) >= target), 64'd1);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " dut0 ctl"}, 64'({rdy0, wr0, hold0, done0, err0}), 64'd0);
        check({name, " dut0 addr/inst"}, {addr0, inst0}, 64'd0);
        check({name, " dut1 ctl"}, 64'({rdy1, wr1, hold1, done1, err1}), 64'd0);
        check({name, " dut1 addr/inst"}, {addr1, inst1}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start0 = 1'b0; start1 = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Basic two-word load
        exp0.push_back({32'h0, 32'h0000_0013});
        exp0.push_back({32'h4, 32'h0010_0093});
        pulse_start(0);
        check("basic hold/ready after start", 64'({hold0, rdy0}), 64'b11);
        send_word(32'd2, 0);
        send_word(32'h0000_0013, 0);
        send_word(32'h0010_0093, 0);
        wait_done(0, 1, "basic done");
        @(negedge clk);
        check("basic writes drained", 64'(exp0.size()), 64'd0);
        check("basic hold released", 64'(hold0), 64'd0);

        // Zero count
        pulse_start(0);
        send_word(32'd0, 0);
        wait_done(0, 2, "zero done");
        @(negedge clk);
        check("zero back to idle", 64'({hold0, rdy0, err0}), 64'd0);

        // Overflow: N = 2049
        pulse_start(0);
        send_word(32'h0000_0801, 0);
        repeat (2) @(negedge clk);
        check("overflow err/ready/hold", 64'({err0, rdy0, hold0}), 64'b101);
        check("overflow no done", 64'(done_cnt0), 64'd2);
        exp0.push_back({32'h0, 32'hCAFE_F00D});
        pulse_start(0);
        check("restart clears err", 64'({err0, hold0, rdy0}), 64'b011);
        send_word(32'd1, 0);
        send_word(32'hCAFE_F00D, 0);
        wait_done(0, 3, "post-error load done");

        // Gapped stream
        exp0.push_back({32'h0, 32'hDEAD_BEEF});
        pulse_start(0);
        send_word(32'd1, 2);
        send_word(32'hDEAD_BEEF, 2);
        wait_done(0, 4, "gapped done");
        check("gapped writes drained", 64'(exp0.size()), 64'd0);

        // Reset in the middle of word 1 of a 3-word load
        exp0.push_back({32'h0, 32'h1111_1111});
        pulse_start(0);
        send_word(32'd3, 0);
        send_word(32'h1111_1111, 0);
        send_byte(8'h22, 0);
        send_byte(8'h22, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid-word reset");
        rst = 1'b0;
        check("mid-word first word written", 64'(exp0.size()), 64'd0);
        exp0.push_back({32'h0, 32'h0102_0304});
        pulse_start(0);
        send_word(32'd1, 0);
        send_word(32'h0102_0304, 0);
        wait_done(0, 5, "fresh load done");

        // N == DEPTH on the small instance, with start pulsed during DATA
        sel = 1;
        exp1.push_back({32'h100, 32'hA000_0000});
        exp1.push_back({32'h104, 32'hA111_1111});
        exp1.push_back({32'h108, 32'hA222_2222});
        exp1.push_back({32'h10C, 32'hA333_3333});
        pulse_start(1);
        send_word(32'd4, 0);
        send_word(32'hA000_0000, 0);
        send_byte(8'h11, 0);
        pulse_start(1);
        check("start in DATA ignored", 64'({hold1, rdy1, err1}), 64'b110);
        send_byte(8'h11, 0);
        send_byte(8'h11, 0);
        send_byte(8'hA1, 0);
        send_word(32'hA222_2222, 0);
        send_word(32'hA333_3333, 0);
        wait_done(1, 1, "boundary done");
        @(negedge clk);
        check("boundary writes drained", 64'(exp1.size()), 64'd0);
        check("boundary idle after done", 64'({hold1, rdy1, err1}), 64'd0);
        check("dut0 untouched by dut1 load", 64'(done_cnt0), 64'd5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
